instr_mem_loader: RTL and testbench

Writer side of the instruction memory. Accepts a byte stream over a valid/ready handshake and assembles each pair of bytes into a 16-bit instruction, low byte first. Writes each instruction through a one-cycle write strobe at consecutive addresses from BASE_ADDR. Sits between the host/debug byte link and the instruction memory write port, and holds the core off (busy) while a program is loaded.

---
 rtl/instr_mem_loader.sv | 148 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a byte stream into 16-bit words, low byte first,
// and writes them upward from BASE_ADDR. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module instr_mem_loader #(
   parameter int unsigned       ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] word_count,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int unsigned      CNT_W      = ADDR_W + 1;
   localparam int unsigned      BYTE_W     = 8;
   localparam int unsigned      WORD_W     = 16;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOW,
      S_HIGH,
      S_WRITE,
      S_FINISH,
      S_CHK
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t LAST_STATE = S_CHK;
`else
   localparam state_t LAST_STATE = S_FINISH;
`endif

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  remaining, remaining_nxt;
   logic [BYTE_W-1:0] low_byte, low_byte_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [WORD_W-1:0] mem_wdata_nxt;
   logic              in_ready_nxt, mem_we_nxt, busy_nxt, done_nxt;
   logic              xfer;

   assign xfer = in_valid & in_ready;

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_addr  <= BASE_ADDR;
         mem_wdata <= '0;
         remaining <= '0;
         low_byte  <= '0;
      end else begin
         state     <= state_nxt;
         in_ready  <= in_ready_nxt;
         mem_we    <= mem_we_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_wdata <= mem_wdata_nxt;
         remaining <= remaining_nxt;
         low_byte  <= low_byte_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start) state_nxt = S_LOW;
         S_LOW:    if (xfer) state_nxt = S_HIGH;
         S_HIGH:   if (xfer) state_nxt = S_WRITE;
         S_WRITE:  state_nxt = (remaining == CNT_W'(1)) ? LAST_STATE : S_LOW;
         S_CHK:    if (xfer) state_nxt = S_FINISH;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values; handshake flags decode the upcoming state
   always_comb begin
      in_ready_nxt  = (state_nxt == S_LOW) || (state_nxt == S_HIGH) || (state_nxt == S_CHK);
      mem_we_nxt    = (state_nxt == S_WRITE);
      done_nxt      = (state_nxt == S_FINISH);
      busy_nxt      = (state_nxt != S_IDLE) && (state_nxt != S_FINISH);
      remaining_nxt = remaining;
      low_byte_nxt  = low_byte;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               remaining_nxt = (word_count == '0) ? FULL_COUNT : CNT_W'(word_count);
               mem_addr_nxt  = BASE_ADDR;
            end
         end
         S_LOW:   if (xfer) low_byte_nxt = in_data;
         S_HIGH:  if (xfer) mem_wdata_nxt = {in_data, low_byte};
         S_WRITE: begin
            mem_addr_nxt  = mem_addr + ADDR_W'(1);
            remaining_nxt = remaining - CNT_W'(1);
         end
         default: ;
      endcase
   end

`ifdef LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] chk_acc, chk_acc_nxt;
   logic              err_nxt;

   // Running XOR of data bytes, compared against the trailing checksum byte
   always_comb begin
      chk_acc_nxt = chk_acc;
      err_nxt     = err;
      if ((state == S_IDLE) && start) begin
         chk_acc_nxt = '0;
         err_nxt     = 1'b0;
      end else if (xfer && ((state == S_LOW) || (state == S_HIGH))) begin
         chk_acc_nxt = chk_acc ^ in_data;
      end else if (xfer && (state == S_CHK)) begin
         err_nxt = (in_data != chk_acc);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_acc <= '0;
         err     <= 1'b0;
      end else begin
         chk_acc <= chk_acc_nxt;
         err     <= err_nxt;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: driver pushes expected writes/done events,
// a negedge monitor pops and compares whenever mem_we or done is seen.
`timescale 1ns/1ps
module tb_instr_mem_loader;
   localparam int unsigned       ADDR_W = 8;
   localparam int unsigned       DEPTH  = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] BASE   = '0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] word_count = '0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = '0;
   logic              in_ready, mem_we, busy, done, err;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata;

   instr_mem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .start(start), .word_count(word_count),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned addr;
      int unsigned data;
   } wr_t;
   typedef struct {
      int unsigned addr;
      bit          err;
   } done_t;

   wr_t        exp_wr[$];
   done_t      exp_done[$];
   logic [7:0] stim[$];
   int         checks = 0;
   int         fails = 0;
   int         done_seen = 0;
   logic       prev_we = 1'b0;
   logic       prev_done = 1'b0;
   wr_t        mon_w;
   done_t      mon_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: compare every write strobe and done pulse against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) begin
            check("we_single_cycle", 32'(prev_we), 32'd0);
            check("ready_low_in_write", 32'(in_ready), 32'd0);
            if (exp_wr.size() == 0) begin
               check("unexpected_write", 32'd1, 32'd0);
            end else begin
               mon_w = exp_wr.pop_front();
               check("wr_addr", 32'(mem_addr), mon_w.addr);
               check("wr_data", 32'(mem_wdata), mon_w.data);
            end
         end
         if (done) begin
            check("done_single_cycle", 32'(prev_done), 32'd0);
            check("busy_at_done", 32'(busy), 32'd0);
            check("ready_at_done", 32'(in_ready), 32'd0);
            if (exp_done.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               mon_d = exp_done.pop_front();
               check("final_addr", 32'(mem_addr), mon_d.addr);
               check("err_at_done", 32'(err), 32'(mon_d.err));
            end
            done_seen++;
         end
      end
      prev_we   = mem_we;
      prev_done = done;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n <= 200) begin
         @(negedge clk);
         n++;
      end
      if (n > 200) check("ready_timeout", 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic load_stim(input logic [47:0] v, input int nb);
      stim.delete();
      for (int i = 0; i < nb; i++) stim.push_back(v[8*(nb-1-i) +: 8]);
   endtask

   // One complete load: model the expected writes/done, then drive start and bytes
   task automatic do_load(input logic [ADDR_W-1:0] wc, input int gap, input bit gap_rand,
                          input bit bad_chk, input int poke_at, input bit start_on_done);
      int         n, target, k;
      logic [7:0] x;
      wr_t        w;
      done_t      d;
      n = (wc == '0) ? int'(DEPTH) : int'(wc);
      if (stim.size() != 2 * n) begin
         stim.delete();
         for (int i = 0; i < 2 * n; i++) stim.push_back(8'($urandom));
      end
      x = '0;
      for (int i = 0; i < n; i++) begin
         w.addr = (int'(BASE) + i) % DEPTH;
         w.data = 32'({stim[2*i+1], stim[2*i]});
         exp_wr.push_back(w);
         x = x ^ stim[2*i] ^ stim[2*i+1];
      end
      d.addr = (int'(BASE) + n) % DEPTH;
`ifdef LOADER_CHECKSUM_EN
      d.err = bad_chk;
`else
      d.err = 1'b0;
`endif
      exp_done.push_back(d);
      target = done_seen + 1;

      @(negedge clk);
      word_count = wc;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      word_count = 8'($urandom);
      check("busy_after_start", 32'(busy), 32'd1);
      check("ready_after_start", 32'(in_ready), 32'd1);
      check("err_cleared", 32'(err), 32'd0);

      for (int i = 0; i < 2 * n; i++) begin
         send_byte(stim[i], gap_rand ? $urandom_range(gap, 0) : gap);
         if (i == poke_at) begin
            start      = 1'b1;
            word_count = 8'd5;
            @(negedge clk);
            start = 1'b0;
         end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x ^ (bad_chk ? 8'h07 : 8'h00), 0);
`endif
      if (start_on_done) begin
         k = 0;
         while (!done && k < 50) begin
            @(negedge clk);
            k++;
         end
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("start_on_done_busy", 32'(busy), 32'd0);
         check("start_on_done_ready", 32'(in_ready), 32'd0);
      end
      k = 0;
      while (done_seen < target && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", 32'(done_seen), 32'(target));
      repeat (3) @(negedge clk);
      check("err_hold", 32'(err), 32'(d.err));
      check("addr_hold", 32'(mem_addr), d.addr);
      check("busy_idle", 32'(busy), 32'd0);
      stim.delete();
   endtask

   initial begin
      int d0;
      wr_t w;

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'(BASE));
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b0;

      // in_valid must be ignored while idle
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (5) begin
         @(negedge clk);
         check("idle_ready", 32'(in_ready), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end
      in_valid = 1'b0;

      load_stim(48'h0201_0301_1015, 6);
      do_load(8'd3, 0, 1'b0, 1'b0, -1, 1'b0);
      load_stim(48'h0201_0301_1015, 6);
      do_load(8'd3, 2, 1'b0, 1'b0, -1, 1'b0);

      load_stim(48'h0000_0000_0201, 2);
      do_load(8'd1, 0, 1'b0, 1'b0, -1, 1'b0);
      load_stim(48'h0000_0000_0201, 2);
      do_load(8'd1, 0, 1'b0, 1'b1, -1, 1'b0);

      do_load(8'd4, 1, 1'b1, 1'b0, 3, 1'b1);

      // Abort with reset after the low byte of word 2
      load_stim(48'h1122_3344_5566, 6);
      for (int i = 0; i < 2; i++) begin
         w.addr = (int'(BASE) + i) % DEPTH;
         w.data = 32'({stim[2*i+1], stim[2*i]});
         exp_wr.push_back(w);
      end
      d0 = done_seen;
      @(negedge clk);
      word_count = 8'd3;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(stim[i], 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_ready", 32'(in_ready), 32'd0);
      check("abort_we", 32'(mem_we), 32'd0);
      check("abort_addr", 32'(mem_addr), 32'(BASE));
      check("abort_wdata", 32'(mem_wdata), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_no_done", 32'(done_seen), 32'(d0));
      check("abort_writes", 32'(exp_wr.size()), 32'd0);
      stim.delete();

      do_load(8'd2, 0, 1'b0, 1'b0, -1, 1'b0);
      do_load(8'd0, 0, 1'b0, 1'b0, -1, 1'b0);
      repeat (6) do_load(8'($urandom_range(20, 1)), 3, 1'b1, 1'($urandom_range(1, 0)), -1, 1'b0);

      check("pending_writes", 32'(exp_wr.size()), 32'd0);
      check("pending_done", 32'(exp_done.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
